// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared definitions for the pipeline main-control slice.
//   - MIPS opcode / funct encodings used by the decoder
//   - ALUOp encodings
//   - Control bundle layouts for the ID/EX, EX/MEM and MEM/WB registers
//   - NOP bundle constants (all controls de-asserted)
package pipe_ctrl_unit_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] FUNCT_SLL = 6'h00;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_RFUNCT = 3'b010,
        ALU_AND    = 3'b011,
        ALU_OR     = 3'b100,
        ALU_SLT    = 3'b101
    } aluop_e;

    // Full bundle produced in ID and held in ID/EX.
    typedef struct packed {
        logic   regdst;
        logic   alusrc;
        aluop_e aluop;
        logic   branch;
        logic   branch_ne;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   regwrite;
    } ctrl_t;

    // Subset carried in EX/MEM.
    typedef struct packed {
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
    } mem_ctrl_t;

    // Subset carried in MEM/WB.
    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wb_ctrl_t;

    localparam ctrl_t     CTRL_NOP = '0;
    localparam mem_ctrl_t MEM_NOP  = '0;
    localparam wb_ctrl_t  WB_NOP   = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decoder.sv
// Purely combinational opcode/funct -> control bundle table.
//   opcode_i, funct_i : instruction fields from IF/ID
//   ctrl_o            : decoded control bundle (NOP for unknown / SLL encodings)
//   uses_rt_o         : instruction reads rt as a source (load-use check)
//   jump_o            : instruction is J
module pipe_ctrl_unit_decoder
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int unsigned OPC_W      = 6,
    parameter bit          EN_IMM_OPS = 1'b1
) (
    input  logic [OPC_W-1:0] opcode_i,
    input  logic [OPC_W-1:0] funct_i,
    output ctrl_t            ctrl_o,
    output logic             uses_rt_o,
    output logic             jump_o
);

    logic [5:0] op;
    logic [5:0] fn;

    always_comb begin
        op        = 6'(opcode_i);
        fn        = 6'(funct_i);
        ctrl_o    = CTRL_NOP;
        uses_rt_o = 1'b0;
        jump_o    = 1'b0;
        case (op)
            OP_RTYPE: begin
                // funct 0 is SLL/NOP, treated as a bubble
                if (fn != FUNCT_SLL) begin
                    ctrl_o.regdst   = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.aluop    = ALU_RFUNCT;
                    uses_rt_o       = 1'b1;
                end
            end
            OP_LW: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memread  = 1'b1;
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            OP_SW: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memwrite = 1'b1;
                uses_rt_o       = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.aluop  = ALU_SUB;
                uses_rt_o     = 1'b1;
            end
            OP_BNE: begin
                ctrl_o.branch    = 1'b1;
                ctrl_o.branch_ne = 1'b1;
                ctrl_o.aluop     = ALU_SUB;
                uses_rt_o        = 1'b1;
            end
            OP_J: jump_o = 1'b1;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                if (EN_IMM_OPS) begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                    case (op)
                        OP_SLTI: ctrl_o.aluop = ALU_SLT;
                        OP_ANDI: ctrl_o.aluop = ALU_AND;
                        OP_ORI:  ctrl_o.aluop = ALU_OR;
                        default: ctrl_o.aluop = ALU_ADD;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Main control for the 5-stage MIPS pipeline: decode in ID, control bundle
// carried through ID/EX, EX/MEM, MEM/WB; load-use stall, branch/jump flush,
// saturating stall/flush counters.
//   clk, reset (async, active-high), enable (0 = bubble decode)
//   id_opcode/id_funct/id_rs/id_rt : ID-stage instruction fields
//   ex_branch_tkn                  : EX comparator result (rs==rt)
//   pc_write, ifid_write, if_flush, id_jump : hazard / fetch controls
//   ex_*, mem_*, wb_*              : registered stage controls
//   stall_cnt, flush_cnt           : saturating event counters
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int unsigned OPC_W      = 6,
    parameter int unsigned RA_W       = 5,
    parameter int unsigned ALUOP_W    = 3,
    parameter bit          EN_IMM_OPS = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [OPC_W-1:0]   id_opcode,
    input  logic [OPC_W-1:0]   id_funct,
    input  logic [RA_W-1:0]    id_rs,
    input  logic [RA_W-1:0]    id_rt,
    input  logic               ex_branch_tkn,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               if_flush,
    output logic               id_jump,
    output logic               ex_regdst,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_branch,
    output logic               ex_branch_ne,
    output logic               ex_pc_src,
    output logic               mem_read,
    output logic               mem_write,
    output logic               wb_memtoreg,
    output logic               wb_regwrite,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    ctrl_t            dec_ctrl;
    logic             dec_uses_rt;
    logic             dec_jump;

    ctrl_t            ex_q,  ex_d;
    logic [RA_W-1:0]  ex_rt_q, ex_rt_d;
    mem_ctrl_t        mem_q, mem_d;
    wb_ctrl_t         wb_q,  wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic pc_src;
    logic lu;
    logic jump_go;
    logic uses_rt;

    pipe_ctrl_unit_decoder #(
        .OPC_W      (OPC_W),
        .EN_IMM_OPS (EN_IMM_OPS)
    ) u_decoder (
        .opcode_i  (id_opcode),
        .funct_i   (id_funct),
        .ctrl_o    (dec_ctrl),
        .uses_rt_o (dec_uses_rt),
        .jump_o    (dec_jump)
    );

    always_comb begin
        uses_rt = enable & dec_uses_rt;
        pc_src  = ex_q.branch & (ex_branch_tkn ^ ex_q.branch_ne);
        lu      = ex_q.memread && (ex_rt_q != '0) &&
                  ((ex_rt_q == id_rs) || (uses_rt && (ex_rt_q == id_rt)));
        // Priority: taken branch > load-use > jump
        jump_go = enable & dec_jump & ~pc_src & ~lu;

        pc_write   = pc_src | ~lu;
        ifid_write = pc_src | ~lu;
        if_flush   = pc_src | jump_go;
        id_jump    = jump_go;

        ex_d    = dec_ctrl;
        ex_rt_d = id_rt;
        if (pc_src || lu || !enable) begin
            ex_d    = CTRL_NOP;
            ex_rt_d = '0;
        end

        mem_d = '{memread:  ex_q.memread,  memwrite: ex_q.memwrite,
                  memtoreg: ex_q.memtoreg, regwrite: ex_q.regwrite};
        wb_d  = '{memtoreg: mem_q.memtoreg, regwrite: mem_q.regwrite};

        stall_cnt_d = stall_cnt_q;
        if (lu && !pc_src && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (if_flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= CTRL_NOP;
            ex_rt_q     <= '0;
            mem_q       <= MEM_NOP;
            wb_q        <= WB_NOP;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            ex_rt_q     <= ex_rt_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_regdst    = ex_q.regdst;
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_aluop     = ALUOP_W'(ex_q.aluop);
    assign ex_branch    = ex_q.branch;
    assign ex_branch_ne = ex_q.branch_ne;
    assign ex_pc_src    = pc_src;
    assign mem_read     = mem_q.memread;
    assign mem_write    = mem_q.memwrite;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_regwrite  = wb_q.regwrite;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed-vector bench for pipe_ctrl_unit. Two instances share the stimulus:
// u_dut with default parameters and u_dut2 with EN_IMM_OPS=0, CNT_W=2.
module tb_pipe_ctrl_unit;

    localparam logic [5:0] R    = 6'h00;
    localparam logic [5:0] J    = 6'h02;
    localparam logic [5:0] BEQ  = 6'h04;
    localparam logic [5:0] BNE  = 6'h05;
    localparam logic [5:0] ADDI = 6'h08;
    localparam logic [5:0] SLTI = 6'h0A;
    localparam logic [5:0] LW   = 6'h23;
    localparam logic [5:0] SW   = 6'h2B;
    localparam logic [5:0] ADD  = 6'h20;

    logic       clk = 1'b0;
    logic       reset, enable, ex_branch_tkn;
    logic [5:0] id_opcode, id_funct;
    logic [4:0] id_rs, id_rt;

    logic        pc_write, ifid_write, if_flush, id_jump;
    logic        ex_regdst, ex_alusrc, ex_branch, ex_branch_ne, ex_pc_src;
    logic [2:0]  ex_aluop;
    logic        mem_read, mem_write, wb_memtoreg, wb_regwrite;
    logic [15:0] stall_cnt, flush_cnt;

    logic        d2_pc_write, d2_ifid_write, d2_if_flush, d2_id_jump;
    logic        d2_ex_regdst, d2_ex_alusrc, d2_ex_branch, d2_ex_branch_ne, d2_ex_pc_src;
    logic [2:0]  d2_ex_aluop;
    logic        d2_mem_read, d2_mem_write, d2_wb_memtoreg, d2_wb_regwrite;
    logic [1:0]  d2_stall_cnt, d2_flush_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit u_dut (
        .clk(clk), .reset(reset), .enable(enable),
        .id_opcode(id_opcode), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt),
        .ex_branch_tkn(ex_branch_tkn),
        .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush), .id_jump(id_jump),
        .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
        .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_pc_src(ex_pc_src),
        .mem_read(mem_read), .mem_write(mem_write),
        .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl_unit #(
        .EN_IMM_OPS (1'b0),
        .CNT_W      (2)
    ) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable),
        .id_opcode(id_opcode), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt),
        .ex_branch_tkn(ex_branch_tkn),
        .pc_write(d2_pc_write), .ifid_write(d2_ifid_write), .if_flush(d2_if_flush),
        .id_jump(d2_id_jump),
        .ex_regdst(d2_ex_regdst), .ex_alusrc(d2_ex_alusrc), .ex_aluop(d2_ex_aluop),
        .ex_branch(d2_ex_branch), .ex_branch_ne(d2_ex_branch_ne), .ex_pc_src(d2_ex_pc_src),
        .mem_read(d2_mem_read), .mem_write(d2_mem_write),
        .wb_memtoreg(d2_wb_memtoreg), .wb_regwrite(d2_wb_regwrite),
        .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_id(input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt);
        id_opcode = op;
        id_funct  = fn;
        id_rs     = rs;
        id_rt     = rt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; ex_branch_tkn = 1'b0;
        set_id(R, 6'h00, 5'd0, 5'd0);
        #12;
        check_eq("rst_ex_regdst",  ex_regdst, 0);
        check_eq("rst_ex_alusrc",  ex_alusrc, 0);
        check_eq("rst_ex_aluop",   ex_aluop, 0);
        check_eq("rst_ex_branch",  ex_branch, 0);
        check_eq("rst_mem_read",   mem_read, 0);
        check_eq("rst_mem_write",  mem_write, 0);
        check_eq("rst_wb_regwr",   wb_regwrite, 0);
        check_eq("rst_wb_m2r",     wb_memtoreg, 0);
        check_eq("rst_pc_write",   pc_write, 1);
        check_eq("rst_ifid_write", ifid_write, 1);
        check_eq("rst_if_flush",   if_flush, 0);
        check_eq("rst_stall_cnt",  stall_cnt, 0);
        check_eq("rst_flush_cnt",  flush_cnt, 0);
        reset = 1'b0; enable = 1'b1;

        // Load-use: LW $2 then ADD $3,$2,$4
        set_id(LW, 6'h00, 5'd1, 5'd2); settle();
        check_eq("lw_no_stall", pc_write, 1);
        tick();
        check_eq("lw_ex_alusrc", ex_alusrc, 1);
        set_id(R, ADD, 5'd2, 5'd4); settle();
        check_eq("lu_pc_write",    pc_write, 0);
        check_eq("lu_ifid_write",  ifid_write, 0);
        check_eq("lu_if_flush",    if_flush, 0);
        check_eq("lu_d2_pc_write", d2_pc_write, 0);
        tick();
        check_eq("lu_bubble_regdst", ex_regdst, 0);
        check_eq("lu_bubble_alusrc", ex_alusrc, 0);
        check_eq("lu_mem_read",      mem_read, 1);
        check_eq("lu_stall_cnt",     stall_cnt, 1);
        check_eq("lu_one_cycle",     pc_write, 1);
        tick();
        check_eq("add_ex_regdst", ex_regdst, 1);
        check_eq("add_ex_aluop",  ex_aluop, 2);
        check_eq("lw_wb_regwr",   wb_regwrite, 1);
        check_eq("lw_wb_m2r",     wb_memtoreg, 1);
        set_id(R, 6'h00, 5'd0, 5'd0);
        tick();
        check_eq("gap_wb_regwr", wb_regwrite, 0);
        tick();
        check_eq("add_wb_regwr", wb_regwrite, 1);
        check_eq("add_wb_m2r",   wb_memtoreg, 0);

        // LW to $0 followed by a $0 consumer
        set_id(LW, 6'h00, 5'd1, 5'd0); tick();
        set_id(R, ADD, 5'd0, 5'd0); settle();
        check_eq("lw0_pc_write", pc_write, 1);
        tick();
        check_eq("lw0_stall_cnt", stall_cnt, 1);

        // BEQ taken squashes the ADD in ID
        set_id(BEQ, 6'h00, 5'd1, 5'd2); tick();
        check_eq("beq_ex_branch", ex_branch, 1);
        check_eq("beq_ex_aluop",  ex_aluop, 1);
        set_id(R, ADD, 5'd3, 5'd4); ex_branch_tkn = 1'b1; settle();
        check_eq("beq_pc_src",   ex_pc_src, 1);
        check_eq("beq_if_flush", if_flush, 1);
        check_eq("beq_pc_write", pc_write, 1);
        tick(); ex_branch_tkn = 1'b0;
        check_eq("beq_flush_cnt", flush_cnt, 1);
        check_eq("beq_squash",    ex_regdst, 0);
        check_eq("beq_bubble_br", ex_branch, 0);

        // BNE with equal operands is not taken
        set_id(BNE, 6'h00, 5'd1, 5'd2); tick();
        check_eq("bne_ex_branch_ne", ex_branch_ne, 1);
        set_id(R, 6'h00, 5'd0, 5'd0); ex_branch_tkn = 1'b1; settle();
        check_eq("bne_pc_src",   ex_pc_src, 0);
        check_eq("bne_if_flush", if_flush, 0);
        tick(); ex_branch_tkn = 1'b0;
        check_eq("bne_flush_cnt", flush_cnt, 1);

        // J behind a taken branch, then J alone
        set_id(BEQ, 6'h00, 5'd1, 5'd2); tick();
        set_id(J, 6'h00, 5'd0, 5'd0); ex_branch_tkn = 1'b1; settle();
        check_eq("jbr_id_jump",  id_jump, 0);
        check_eq("jbr_if_flush", if_flush, 1);
        tick(); ex_branch_tkn = 1'b0;
        check_eq("jbr_flush_cnt", flush_cnt, 2);
        settle();
        check_eq("j_id_jump",  id_jump, 1);
        check_eq("j_if_flush", if_flush, 1);
        tick();
        check_eq("j_flush_cnt", flush_cnt, 3);
        check_eq("j_bubble",    ex_alusrc, 0);
        check_eq("j_bubble_br", ex_branch, 0);

        // Immediate ops, enabled vs disabled
        set_id(ADDI, 6'h00, 5'd6, 5'd5); tick();
        check_eq("addi_alusrc",    ex_alusrc, 1);
        check_eq("addi_aluop",     ex_aluop, 0);
        check_eq("addi_d2_alusrc", d2_ex_alusrc, 0);
        set_id(SLTI, 6'h00, 5'd6, 5'd7); tick();
        check_eq("slti_aluop",    ex_aluop, 5);
        check_eq("slti_d2_aluop", d2_ex_aluop, 0);
        set_id(R, 6'h00, 5'd0, 5'd0); tick();
        check_eq("addi_wb_regwr",    wb_regwrite, 1);
        check_eq("addi_d2_wb_regwr", d2_wb_regwrite, 0);

        // enable=0 inserts a bubble while SW drains
        set_id(SW, 6'h00, 5'd1, 5'd2); tick();
        enable = 1'b0; set_id(R, ADD, 5'd1, 5'd2); tick();
        check_eq("en0_regdst",    ex_regdst, 0);
        check_eq("en0_aluop",     ex_aluop, 0);
        check_eq("en0_mem_write", mem_write, 1);
        enable = 1'b1; set_id(R, 6'h00, 5'd0, 5'd0); tick();

        // Five more load-use stalls: 16-bit counter reaches 6, 2-bit saturates at 3
        for (int i = 0; i < 5; i++) begin
            set_id(LW, 6'h00, 5'd1, 5'd3); tick();
            set_id(R, ADD, 5'd3, 5'd0); tick();
            tick();
        end
        check_eq("sat_stall_cnt",    stall_cnt, 6);
        check_eq("sat_d2_stall_cnt", d2_stall_cnt, 3);

        // Asynchronous reset mid-operation
        set_id(LW, 6'h00, 5'd1, 5'd3); tick();
        check_eq("pre_rst_alusrc", ex_alusrc, 1);
        reset = 1'b1; settle();
        check_eq("mid_rst_alusrc",    ex_alusrc, 0);
        check_eq("mid_rst_stall_cnt", stall_cnt, 0);
        check_eq("mid_rst_flush_cnt", flush_cnt, 0);
        check_eq("mid_rst_pc_write",  pc_write, 1);
        reset = 1'b0;
        set_id(R, ADD, 5'd1, 5'd2); tick();
        check_eq("post_rst_regdst", ex_regdst, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
